// File: rtl/bist_pkg.sv
// BIST response analyzer shared types, default parameters and MISR step function.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int          DEF_CHAIN_LEN    = 8;
    localparam int          DEF_NUM_PATTERNS = 16;
    localparam logic [7:0]  DEF_MISR_POLY    = 8'h1D;
    localparam logic [7:0]  DEF_MISR_SEED    = 8'hFF;

    // One serial MISR step: shift left, fold in the incoming bit through the taps.
    function automatic logic [7:0] misr_step(input logic [7:0] sig,
                                             input logic       din,
                                             input logic [7:0] poly);
        logic fb;
        fb = sig[7] ^ din;
        return {sig[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Serial-input 8-bit MISR; clr reloads the seed, en compacts one din bit.
// Latency: signature reflects din one clock after the enabled edge.
// Backpressure: none; updates only when en is high, clr has priority.
module bist_misr
    import bist_pkg::*;
#(
    parameter logic [7:0] POLY = DEF_MISR_POLY,
    parameter logic [7:0] SEED = DEF_MISR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] sig
);

    // Seed on reset or clear, otherwise compact one bit per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SEED;
        end else if (clr) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr_step(sig, din, POLY);
        end
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// Output-side BIST controller: sequences scan_en and compacts scan_out into an MISR,
// done 152 cycles (default) after an accepted start; pass registered on entry to DONE.
// No backpressure: start is sampled only in IDLE/DONE and ignored while busy.
// Optional BIST_FAULT_INJECT_EN adds fault_inj, which inverts the compacted bit.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int         CHAIN_LEN    = DEF_CHAIN_LEN,
    parameter int         NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter logic [7:0] MISR_POLY    = DEF_MISR_POLY,
    parameter logic [7:0] MISR_SEED    = DEF_MISR_SEED,
    parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scan_out,
`ifdef BIST_FAULT_INJECT_EN
    input  logic       fault_inj,
`endif
    output logic       scan_en,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    localparam int BIT_W = (CHAIN_LEN    > 1) ? $clog2(CHAIN_LEN)    : 1;
    localparam int PAT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [PAT_W-1:0] pat_cnt;
    logic             start_ok;
    logic             misr_en;
    logic             misr_din;

    // Outputs are pure decodes of the state register so reset acts on them immediately.
    assign scan_en  = (state != CAPTURE);
    assign busy     = (state == SHIFT) || (state == CAPTURE) || (state == UNLOAD);
    assign done     = (state == DONE);
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign misr_en  = (state == SHIFT) || (state == UNLOAD);

`ifdef BIST_FAULT_INJECT_EN
    assign misr_din = scan_out ^ fault_inj;
`else
    assign misr_din = scan_out;
`endif

    // Shift/capture schedule, counters and the registered pass verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pat_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        pat_cnt <= '0;
                        pass    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= CAPTURE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    pat_cnt <= pat_cnt + 1'b1;
                    state   <= (pat_cnt == LAST_PAT) ? UNLOAD : SHIFT;
                end
                UNLOAD: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        state   <= DONE;
                        // The MISR takes its last update on this same edge, so judge the
                        // value it is about to hold rather than the current one.
                        pass    <= (misr_step(signature, misr_din, MISR_POLY) == GOLDEN_SIG);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bist_misr #(
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (misr_en),
        .din (misr_din),
        .sig (signature)
    );

endmodule
